nor_32bit: RTL and testbench

//  Bitwise 32-bit NOR unit for the ALU logic-operation datapath: out = ~(a | b).
//  A registered stage with a valid qualifier, so the ALU result mux receives a

---
 rtl/nor_32bit.sv | 58 +++++
 tb/tb_nor_32bit.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/nor_32bit.sv
// Bitwise NOR unit for the ALU logic-operation datapath: out = ~(a | b),
// optionally registered with a valid qualifier and an all-zero flag.
module nor_32bit #(
    parameter int unsigned WIDTH        = 32,
    parameter bit          REGISTER_OUT = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             in_valid,
    output logic [WIDTH-1:0] out,
    output logic             out_valid,
    output logic             out_zero
);

    logic [WIDTH-1:0] nor_bits;
    logic             nor_zero;

    for (genvar i = 0; i < WIDTH; i++) begin : g_slice
        assign nor_bits[i] = ~(a[i] | b[i]);
    end

    // Zero flag is derived from the slice outputs so it always agrees with out.
    assign nor_zero = ~|nor_bits;

    if (REGISTER_OUT) begin : g_reg
        logic [WIDTH-1:0] out_q;
        logic             zero_q;
        logic             valid_q;

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                out_q   <= '0;
                zero_q  <= 1'b1;
                valid_q <= 1'b0;
            end else begin
                valid_q <= in_valid;
                if (in_valid) begin
                    out_q  <= nor_bits;
                    zero_q <= nor_zero;
                end
            end
        end

        assign out       = out_q;
        assign out_zero  = zero_q;
        assign out_valid = valid_q;
    end else begin : g_comb
        logic unused_clk_rst;
        assign unused_clk_rst = clk ^ rst_n;

        assign out       = nor_bits;
        assign out_zero  = nor_zero;
        assign out_valid = in_valid;
    end

endmodule

// File: tb/tb_nor_32bit.sv
// Self-checking bench for nor_32bit: registered and combinational instances
// driven in parallel and compared against a behavioural model.
module tb_nor_32bit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] a;
    logic [31:0] b;
    logic        in_valid;

    logic [31:0] out_r, out_c;
    logic        valid_r, valid_c;
    logic        zero_r, zero_c;

    int unsigned checks = 0;
    int unsigned errors = 0;

    logic [31:0] m_out;
    logic        m_zero;
    logic        m_valid;

    nor_32bit #(.WIDTH(32), .REGISTER_OUT(1'b1)) dut_reg (
        .clk       (clk),
        .rst_n     (rst_n),
        .a         (a),
        .b         (b),
        .in_valid  (in_valid),
        .out       (out_r),
        .out_valid (valid_r),
        .out_zero  (zero_r)
    );

    nor_32bit #(.WIDTH(32), .REGISTER_OUT(1'b0)) dut_comb (
        .clk       (clk),
        .rst_n     (rst_n),
        .a         (a),
        .b         (b),
        .in_valid  (in_valid),
        .out       (out_c),
        .out_valid (valid_c),
        .out_zero  (zero_c)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Apply one cycle of inputs: check the combinational instance before the
    // edge, then advance the model and check the registered instance after it.
    task automatic step(input logic [31:0] ta, input logic [31:0] tb_v,
                        input logic tv, input logic tr, input string tag);
        logic [31:0] expect_nor;
        a        = ta;
        b        = tb_v;
        in_valid = tv;
        rst_n    = tr;
        expect_nor = 32'hFFFF_FFFF - (ta | tb_v);
        #1;
        check({tag, "_comb_out"},   out_c,   expect_nor);
        check({tag, "_comb_zero"},  {31'd0, zero_c},  {31'd0, expect_nor == 32'd0});
        check({tag, "_comb_valid"}, {31'd0, valid_c}, {31'd0, tv});
        @(posedge clk);
        if (!tr) begin
            m_out   = 32'd0;
            m_valid = 1'b0;
        end else begin
            m_valid = tv;
            if (tv) m_out = expect_nor;
        end
        m_zero = (m_out == 32'd0);
        #1;
        check({tag, "_reg_out"},   out_r,   m_out);
        check({tag, "_reg_zero"},  {31'd0, zero_r},  {31'd0, m_zero});
        check({tag, "_reg_valid"}, {31'd0, valid_r}, {31'd0, m_valid});
    endtask

    initial begin
        m_out = 32'd0; m_zero = 1'b1; m_valid = 1'b0;
        a = 32'd0; b = 32'd0; in_valid = 1'b0; rst_n = 1'b0;

        // Reset state
        step(32'h1234_5678, 32'h0, 1'b1, 1'b0, "rst0");
        step(32'h0, 32'h0, 1'b0, 1'b0, "rst1");
        check("rst_out_const",  out_r, 32'h0);
        check("rst_zero_const", {31'd0, zero_r}, 32'd1);

        // One operand all ones
        step(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b1, "t1");
        check("t1_out_const",  out_r, 32'h0000_0000);
        check("t1_zero_const", {31'd0, zero_r}, 32'd1);

        step(32'h1231_1111, 32'h0010_0000, 1'b1, 1'b1, "t2");
        check("t2_out_const", out_r, 32'hEDCE_EEEE);

        // Back-to-back
        step(32'h1000_0100, 32'h1100_0010, 1'b1, 1'b1, "t3a");
        check("t3a_out_const", out_r, 32'hEEFF_FEEF);
        step(32'h1111_1000, 32'h0000_1111, 1'b1, 1'b1, "t3b");
        check("t3b_out_const", out_r, 32'hEEEE_EEEE);

        // All-zero operands, then hold
        step(32'h0, 32'h0, 1'b1, 1'b1, "t4a");
        check("t4a_out_const", out_r, 32'hFFFF_FFFF);
        step(32'hFFFF_0000, 32'h00FF_00FF, 1'b0, 1'b1, "t4b");
        check("t4b_hold_const",  out_r, 32'hFFFF_FFFF);
        check("t4b_valid_const", {31'd0, valid_r}, 32'd0);

        // Reset mid-stream drops the input
        step(32'h0, 32'h0, 1'b1, 1'b0, "t5a");
        check("t5a_out_const", out_r, 32'h0);
        step(32'h0F0F_0F0F, 32'h0000_0000, 1'b1, 1'b1, "t5b");
        check("t5b_out_const", out_r, 32'hF0F0_F0F0);

        // Random vectors with occasional idle cycles and resets
        for (int i = 0; i < 1000; i++) begin
            logic [31:0] ra, rb;
            logic        rv, rr;
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 9))
                0: ra = 32'hFFFF_FFFF;
                1: begin ra = 32'h0; rb = 32'h0; end
                2: rb = ~ra;
                default: ;
            endcase
            rv = ($urandom_range(0, 3) != 0);
            rr = ($urandom_range(0, 63) != 0);
            step(ra, rb, rv, rr, "rnd");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
